wb_bus_if: RTL
==============

Name: wb_bus_if

Overview:
- Bridges one openmips memory port (instruction `rom_*` side or data `ram_*` side) to a Wishbone B4 classic master port. Two instances sit directly downstream of the core top: one for instruction fetch, one for data.
- Converts the core's single-cycle ce/we/sel/addr request into a multi-cycle stb/cyc/ack transaction.
- Raises a pipeline stall request until ack returns.
- Honours the ctrl block's `stall` vector and `flush`.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_W, 4, byte-select width (DATA_W/8).
- STALL_W, 6, width of the ctrl stall vector.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  STALL_W  ctrl stall vector; nonzero means the pipeline is frozen.
- flush_i  in  1  ctrl flush (exception); aborts any outstanding transaction.
- cpu_ce_i  in  1  core request valid.
- cpu_addr_i  in  ADDR_W  core address.
- cpu_data_i  in  DATA_W  core write data.
- cpu_we_i  in  1  1 = write.
- cpu_sel_i  in  SEL_W  byte enables.
- cpu_data_o  out  DATA_W  read data to core (combinational).
- stallreq_o  out  1  stall request to ctrl (combinational).
- wb_data_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone ack.
- wb_addr_o  out  ADDR_W  registered.
- wb_data_o  out  DATA_W  registered.
- wb_we_o  out  1  registered.
- wb_sel_o  out  SEL_W  registered.
- wb_stb_o  out  1  registered.
- wb_cyc_o  out  1  registered.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - All wb_* outputs = 0.
  - rd_buf = 0.
- FSM states: IDLE, BUSY, WAIT_FOR_STALL.
- IDLE, sequential:
  - If cpu_ce_i=1 and flush_i=0: next edge loads wb_addr_o/wb_data_o/wb_we_o/wb_sel_o from the cpu_* inputs, sets wb_stb_o=wb_cyc_o=1, clears rd_buf, and moves to BUSY.
  - Otherwise stays in IDLE.
- BUSY, sequential:
  - flush_i=1, with or without wb_ack_i: stb/cyc/we/sel/addr/data cleared, rd_buf=0, go to IDLE. Flush has priority over ack.
  - Else wb_ack_i=1: stb/cyc/we/sel/addr/data cleared. If the access was a read, rd_buf <= wb_data_i. Go to WAIT_FOR_STALL if stall_i≠0, else to IDLE.
  - Else: hold all outputs.
- WAIT_FOR_STALL, sequential:
  - stall_i=0 → IDLE.
  - flush_i=1 → IDLE, rd_buf=0.
  - Else hold.
- Combinational outputs, defaults stallreq_o=0, cpu_data_o=0:
  - IDLE: stallreq_o = cpu_ce_i & ~flush_i.
  - BUSY, ack=1 and no flush: stallreq_o=0; cpu_data_o = wb_we_o ? 0 : wb_data_i (same-cycle forwarding).
  - BUSY, no ack: stallreq_o = ~flush_i.
  - WAIT_FOR_STALL: stallreq_o=0; cpu_data_o = rd_buf, presented until the pipeline advances.
- Latency:
  - Minimum 2 cycles from cpu_ce_i to data: 1 request-issue edge plus ack in the following cycle.
  - Each ack wait state adds one cycle.
- Protocol:
  - stb and cyc always equal.
  - Exactly one ack consumed per transaction; no pipelined or burst cycles.
  - Ack seen in IDLE or WAIT_FOR_STALL is ignored.
- Address/data are not aligned or checked here. Alignment exceptions are detected upstream in mem.
- Reset mid-transaction: outputs drop to 0 on the reset edge; a late ack is ignored.

Decomposition:
- Shared package/defines holds:
  - state encodings: `WB_IDLE`=2'b00, `WB_BUSY`=2'b01, `WB_WAIT_FOR_STALL`=2'b11;
  - `RstEnable`, `ChipEnable`, `WriteEnable`, `ZeroWord`, `RegBus`, from the existing defines.
- No sub-module; single FSM file.
- The top-level SoC wrapper instantiates two copies (iwishbone, dwishbone) and ORs their stallreq_o into ctrl.

Test Plan:
- Read, 1 wait state: cpu_ce_i=1, we=0, addr=0x0000_0100; ack after 2 cycles with wb_data_i=0xDEAD_BEEF, stall_i=0.
  - stb/cyc high from edge 1 until the ack edge.
  - stallreq_o=1 until the ack cycle.
  - cpu_data_o=0xDEAD_BEEF in the ack cycle.
  - wb_addr_o=0x100, wb_sel_o=4'hF during the cycle.
- Write: we=1, sel=4'b0011, data=0x1234_5678, addr=0x40; immediate ack.
  - wb_we_o=1, wb_data_o=0x1234_5678.
  - cpu_data_o=0 in the ack cycle.
  - Returns to IDLE.
- Ack while stalled: read returns 0xCAFE_0001 with stall_i=6'b000111 held for 3 cycles.
  - Enter WAIT_FOR_STALL.
  - cpu_data_o=0xCAFE_0001 for all 3 cycles, stallreq_o=0.
  - Back to IDLE when stall_i=0.
- Flush mid-transaction: flush_i=1 in BUSY before ack.
  - Next edge stb/cyc=0, state IDLE.
  - A later ack has no effect, and cpu_data_o stays 0.
- Flush and ack in the same cycle:
  - Transaction discarded, rd_buf=0, IDLE, stallreq_o=0.
- Sync reset in BUSY: rst=1 for one edge.
  - All wb_* outputs = 0, IDLE.
  - Core request with ce=1 after reset issues a fresh cycle.

Source files
------------

// File: rtl/wb_bus_if_pkg.sv
// Shared constants for the openmips-to-Wishbone bridge: FSM encodings and
// the core's legacy control-level and word-size constants.
package wb_bus_if_pkg;

   localparam logic [1:0] WB_IDLE           = 2'b00;
   localparam logic [1:0] WB_BUSY           = 2'b01;
   localparam logic [1:0] WB_WAIT_FOR_STALL = 2'b11;

   localparam logic        RstEnable   = 1'b1;
   localparam logic        ChipEnable  = 1'b1;
   localparam logic        WriteEnable = 1'b1;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam int          RegBus      = 32;

endpackage

// File: rtl/wb_bus_if.sv
// Bridges one openmips memory port to a Wishbone B4 classic master, stalling
// the pipeline until the single ack of each transaction returns.
//
// state             | meaning
// ------------------+-------------------------------------------------------
// WB_IDLE           | no cycle on the bus; accepts a new core request
// WB_BUSY           | stb/cyc asserted, waiting for the slave's ack
// WB_WAIT_FOR_STALL | read data captured, held for the core until stall clears
module wb_bus_if
   import wb_bus_if_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SEL_W   = 4,
   parameter int STALL_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               cpu_ce_i,
   input  logic [ADDR_W-1:0]  cpu_addr_i,
   input  logic [DATA_W-1:0]  cpu_data_i,
   input  logic               cpu_we_i,
   input  logic [SEL_W-1:0]   cpu_sel_i,
   output logic [DATA_W-1:0]  cpu_data_o,
   output logic               stallreq_o,
   input  logic [DATA_W-1:0]  wb_data_i,
   input  logic               wb_ack_i,
   output logic [ADDR_W-1:0]  wb_addr_o,
   output logic [DATA_W-1:0]  wb_data_o,
   output logic               wb_we_o,
   output logic [SEL_W-1:0]   wb_sel_o,
   output logic               wb_stb_o,
   output logic               wb_cyc_o
);

   logic [1:0]        state;
   logic [DATA_W-1:0] rd_buf;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state     <= WB_IDLE;
         wb_addr_o <= '0;
         wb_data_o <= '0;
         wb_we_o   <= 1'b0;
         wb_sel_o  <= '0;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
         rd_buf    <= '0;
      end else begin
         case (state)
            WB_IDLE: begin
               if (cpu_ce_i == ChipEnable && !flush_i) begin
                  wb_addr_o <= cpu_addr_i;
                  wb_data_o <= cpu_data_i;
                  wb_we_o   <= cpu_we_i;
                  wb_sel_o  <= cpu_sel_i;
                  wb_stb_o  <= 1'b1;
                  wb_cyc_o  <= 1'b1;
                  rd_buf    <= '0;
                  state     <= WB_BUSY;
               end
            end
            WB_BUSY: begin
               // Flush wins over a coincident ack: the access is simply dropped.
               if (flush_i) begin
                  wb_addr_o <= '0;
                  wb_data_o <= '0;
                  wb_we_o   <= 1'b0;
                  wb_sel_o  <= '0;
                  wb_stb_o  <= 1'b0;
                  wb_cyc_o  <= 1'b0;
                  rd_buf    <= '0;
                  state     <= WB_IDLE;
               end else if (wb_ack_i) begin
                  wb_addr_o <= '0;
                  wb_data_o <= '0;
                  wb_we_o   <= 1'b0;
                  wb_sel_o  <= '0;
                  wb_stb_o  <= 1'b0;
                  wb_cyc_o  <= 1'b0;
                  if (wb_we_o != WriteEnable) begin
                     rd_buf <= wb_data_i;
                  end
                  state <= (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
               end
            end
            WB_WAIT_FOR_STALL: begin
               if (stall_i == '0) begin
                  state <= WB_IDLE;
               end else if (flush_i) begin
                  rd_buf <= '0;
                  state  <= WB_IDLE;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

   // Ack-cycle read data is forwarded straight through so the core sees it
   // in the same cycle stallreq drops.
   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = DATA_W'(ZeroWord);
      case (state)
         WB_IDLE: begin
            stallreq_o = (cpu_ce_i == ChipEnable) && !flush_i;
         end
         WB_BUSY: begin
            if (wb_ack_i && !flush_i) begin
               cpu_data_o = (wb_we_o == WriteEnable) ? DATA_W'(ZeroWord) : wb_data_i;
            end else if (!wb_ack_i) begin
               stallreq_o = !flush_i;
            end
         end
         WB_WAIT_FOR_STALL: begin
            cpu_data_o = rd_buf;
         end
         default: begin
            stallreq_o = 1'b0;
         end
      endcase
   end

endmodule
